// File: rtl/interp_lin_stream_if.sv
// ---------------------------------------------------------------------------
// interp_lin_stream_if
// Input sample stream for the linear interpolator: one signed sample per
// transfer, with a valid/ready handshake.
//   v_in      signed sample from the source
//   in_valid  v_in holds a sample this cycle
//   in_ready  sink can take a sample this cycle
// Modports: master = sample source, slave = interpolator.
// ---------------------------------------------------------------------------
interface interp_lin_stream_if #(
   parameter int WIDTH = 20
);
   logic signed [WIDTH-1:0] v_in;
   logic                    in_valid;
   logic                    in_ready;

   modport master (output v_in, output in_valid, input in_ready);
   modport slave  (input v_in, input in_valid, output in_ready);
endinterface

// File: rtl/interp_lin_stream.sv
// ---------------------------------------------------------------------------
// interp_lin_stream
// Upsamples a stream of signed samples by RATIO using exact linear
// interpolation. Each accepted sample starts a sequential divider that
// produces the floor quotient/remainder of (sample - current target) / RATIO.
// A Bresenham error accumulator then walks the segment so that every point
// is base + floor((target-base)*k/RATIO), and the segment lands exactly on
// the next sample. Optional zero-order-hold mode and sticky overrun/underrun
// flags.
//
// Ports:
//   clock      fast clock
//   reset      synchronous, active-high
//   s_in       sample stream (v_in, in_valid, in_ready), slave side
//   mode       0 = linear, 1 = zero-order hold; sampled at segment load
//   flag_clr   clears the sticky flags (a coincident set wins)
//   interp_o   interpolated output sample, signed
//   out_valid  high from the first segment load onward
//   overrun    sticky: a sample was offered while in_ready was low (dropped)
//   underrun   sticky: a segment ended with no next sample pending
//
// state | meaning
// ------+--------------------------------------------------------------
// HOLD  | no segment in progress, interp_o constant, waiting for a sample
// RUN   | stepping through a segment, phase 0..RATIO-1
// ---------------------------------------------------------------------------
module interp_lin_stream #(
   parameter int WIDTH = 20,
   parameter int RATIO = 50
) (
   input  logic                    clock,
   input  logic                    reset,
   interp_lin_stream_if.slave      s_in,
   input  logic                    mode,
   input  logic                    flag_clr,
   output logic signed [WIDTH-1:0] interp_o,
   output logic                    out_valid,
   output logic                    overrun,
   output logic                    underrun
);

   localparam int QW = WIDTH + 1;
   localparam int RW = $clog2(RATIO);
   localparam int CW = $clog2(WIDTH + 2);

   localparam logic [RW:0]   RATIO_E   = (RW+1)'(RATIO);
   localparam logic [RW-1:0] PHASE_END = RW'(RATIO - 1);
   localparam logic [CW-1:0] DIV_ITERS = CW'(WIDTH + 1);

   localparam logic [0:0] HOLD = 1'b0;
   localparam logic [0:0] RUN  = 1'b1;

   // The divider must finish inside one segment for back-to-back streaming.
   generate
      if (RATIO < WIDTH + 3) begin : g_ratio_check
         $error("interp_lin_stream: RATIO must be at least WIDTH+3");
      end
   endgenerate

   // segment registers
   logic [0:0]              state;
   logic [RW-1:0]           phase;
   logic signed [WIDTH-1:0] base;
   logic signed [WIDTH-1:0] target;
   logic signed [QW-1:0]    q;
   logic [RW-1:0]           r;
   logic [RW-1:0]           err;

   // pending sample and its step
   logic signed [WIDTH-1:0] pend_s;
   logic signed [QW-1:0]    pend_q;
   logic [RW-1:0]           pend_r;
   logic                    pend_full;

   // divider
   logic                    div_busy;
   logic [CW-1:0]           div_cnt;
   logic                    div_neg;
   logic [QW-1:0]           div_dq;
   logic [RW-1:0]           div_rem;

   logic                    accept;
   logic                    load;
   logic                    ovr_set;
   logic                    und_set;

   logic signed [QW-1:0]    diff;
   logic [QW-1:0]           diff_mag;
   logic [RW:0]             trial;
   logic                    trial_ge;
   logic [RW-1:0]           rem_next;
   logic [QW-1:0]           dq_p1;
   logic signed [QW-1:0]    fix_q;
   logic [RW-1:0]           fix_r;

   logic [RW:0]             err_sum;
   logic                    carry;
   logic [RW-1:0]           err_next;
   logic [QW-1:0]           inc;
   logic signed [WIDTH-1:0] interp_step;

   // ---------------------------------------------------------------------
   // handshake and control
   // ---------------------------------------------------------------------
   assign s_in.in_ready = !pend_full && !div_busy;
   assign accept        = s_in.in_valid && s_in.in_ready;
   assign ovr_set       = s_in.in_valid && !s_in.in_ready;
   assign load          = pend_full && ((state == HOLD) || (phase == PHASE_END));
   assign und_set       = (state == RUN) && (phase == PHASE_END) && !pend_full && out_valid;

   // ---------------------------------------------------------------------
   // divider datapath
   // ---------------------------------------------------------------------
   // One extra bit keeps the difference of two full-scale samples exact.
   assign diff     = {s_in.v_in[WIDTH-1], s_in.v_in} - {target[WIDTH-1], target};
   assign diff_mag = diff[QW-1] ? QW'(-diff) : QW'(diff);

   // Restoring step: remainder shifted left with the next dividend bit.
   assign trial    = {div_rem, div_dq[QW-1]};
   assign trial_ge = (trial >= RATIO_E);
   assign rem_next = trial_ge ? RW'(trial - RATIO_E) : RW'(trial);

   // Sign fixup turns the truncating magnitude result into a floor result
   // with a non-negative remainder.
   assign dq_p1 = div_dq + 1'b1;

   always_comb begin
      fix_q = $signed(div_dq);
      fix_r = div_rem;
      if (div_neg) begin
         if (div_rem != '0) begin
            fix_q = $signed(-dq_p1);
            fix_r = RW'(RATIO_E - {1'b0, div_rem});
         end else begin
            fix_q = $signed(-div_dq);
            fix_r = '0;
         end
      end
   end

   // ---------------------------------------------------------------------
   // step datapath
   // ---------------------------------------------------------------------
   assign err_sum     = {1'b0, err} + {1'b0, r};
   assign carry       = (err_sum >= RATIO_E);
   assign err_next    = carry ? RW'(err_sum - RATIO_E) : RW'(err_sum);
   assign inc         = carry ? QW'(q + 1'b1) : QW'(q);
   // The exact walk stays between base and target, so truncation is safe.
   assign interp_step = WIDTH'(interp_o + inc);

   // ---------------------------------------------------------------------
   // divider and pending sample
   // ---------------------------------------------------------------------
   always_ff @(posedge clock) begin
      if (reset) begin
         div_busy  <= 1'b0;
         div_cnt   <= '0;
         div_neg   <= 1'b0;
         div_dq    <= '0;
         div_rem   <= '0;
         pend_s    <= '0;
         pend_q    <= '0;
         pend_r    <= '0;
         pend_full <= 1'b0;
      end else begin
         if (load) begin
            pend_full <= 1'b0;
         end
         if (accept) begin
            pend_s   <= s_in.v_in;
            div_busy <= 1'b1;
            div_cnt  <= DIV_ITERS;
            div_neg  <= diff[QW-1];
            div_dq   <= diff_mag;
            div_rem  <= '0;
         end else if (div_busy) begin
            if (div_cnt != '0) begin
               div_cnt <= div_cnt - 1'b1;
               div_rem <= rem_next;
               div_dq  <= {div_dq[QW-2:0], trial_ge};
            end else begin
               div_busy  <= 1'b0;
               pend_q    <= fix_q;
               pend_r    <= fix_r;
               pend_full <= 1'b1;
            end
         end
      end
   end

   // ---------------------------------------------------------------------
   // segment sequencer
   // ---------------------------------------------------------------------
   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= HOLD;
         phase     <= '0;
         base      <= '0;
         target    <= '0;
         interp_o  <= '0;
         q         <= '0;
         r         <= '0;
         err       <= '0;
         out_valid <= 1'b0;
      end else if (load) begin
         base      <= target;
         target    <= pend_s;
         interp_o  <= target;
         phase     <= '0;
         err       <= '0;
         state     <= RUN;
         out_valid <= 1'b1;
         if (mode) begin
            q <= '0;
            r <= '0;
         end else begin
            q <= pend_q;
            r <= pend_r;
         end
      end else if (state == RUN) begin
         if (phase != PHASE_END) begin
            phase    <= phase + 1'b1;
            err      <= err_next;
            interp_o <= interp_step;
         end else begin
            interp_o <= target;
            state    <= HOLD;
         end
      end
   end

   // ---------------------------------------------------------------------
   // sticky flags
   // ---------------------------------------------------------------------
   always_ff @(posedge clock) begin
      if (reset) begin
         overrun  <= 1'b0;
         underrun <= 1'b0;
      end else begin
         if (flag_clr) begin
            overrun  <= 1'b0;
            underrun <= 1'b0;
         end
         if (ovr_set) begin
            overrun <= 1'b1;
         end
         if (und_set) begin
            underrun <= 1'b1;
         end
      end
   end

   // The output never leaves the span of the current segment.
   a_in_span: assert property (@(posedge clock) disable iff (reset)
      out_valid |-> ((interp_o >= base && interp_o <= target) ||
                     (interp_o <= base && interp_o >= target)));

endmodule
